digit_reader: RTL and testbench

Read-side companion to the pi calculator's result RAM. Once the calculator reaches its final phase, this block drives the RAM read address and takes each returned 10-bit base-1000 word. It converts each word to decimal digits and streams them one at a time over a valid/ready handshake to the display/text-buffer logic. It runs on the same clock that clocks the result RAM during the read phase.

---
 rtl/digit_reader.sv | 194 +++++++++++++++++++
 tb/tb_digit_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/digit_reader.sv
// Reads the pi result RAM from the integer word (L-1) down to word 0 and streams
// decimal digits over valid/ready. Define DIGIT_READER_POINT_EN to emit 4'hA after the integer digit.
module digit_reader #(
  parameter int L        = 60,
  parameter int ADR_BITS = 6,
  parameter int N        = 10,
  parameter int RAMDELAY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADR_BITS-1:0] rd_addr,
  input  logic [N-1:0]        rd_data,
  output logic [3:0]          digit,
  output logic                digit_valid,
  input  logic                digit_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

`ifdef DIGIT_READER_POINT_EN
  localparam bit POINT_EN = 1'b1;
`else
  localparam bit POINT_EN = 1'b0;
`endif

  // digit/digit_valid follow valid/ready: a transfer happens on any clock with
  // both high; while valid is high and ready low, digit holds and valid stays up.
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CONV, S_EMIT, S_NEXT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [N-1:0]        rem_q, rem_d;
  logic [3:0]          hund_q, hund_d;
  logic [3:0]          tens_q, tens_d;
  logic [1:0]          idx_q, idx_d;
  logic [3:0]          digit_q, digit_d;
  logic                digit_valid_q, digit_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic is_int;
  logic xfer;

  assign is_int = (rd_addr_q == ADR_BITS'(L - 1));
  assign xfer   = digit_valid_q & digit_ready;

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    wait_cnt_d    = wait_cnt_q;
    rem_d         = rem_q;
    hund_d        = hund_q;
    tens_d        = tens_q;
    idx_d         = idx_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_addr_d  = ADR_BITS'(L - 1);
          wait_cnt_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 8'(RAMDELAY - 1)) begin
          // Out-of-range words skip the iteration and read back as 999.
          if (int'(rd_data) > 999) begin
            err_d  = 1'b1;
            rem_d  = N'(9);
            hund_d = 4'd9;
            tens_d = 4'd9;
          end else begin
            rem_d  = rd_data;
            hund_d = 4'd0;
            tens_d = 4'd0;
          end
          state_d = S_CONV;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_CONV: begin
        if (rem_q >= N'(100)) begin
          rem_d  = rem_q - N'(100);
          hund_d = hund_q + 4'd1;
        end else if (rem_q >= N'(10)) begin
          rem_d  = rem_q - N'(10);
          tens_d = tens_q + 4'd1;
        end else begin
          digit_valid_d = 1'b1;
          state_d       = S_EMIT;
          if (is_int) begin
            digit_d = rem_q[3:0];
            idx_d   = 2'd2;
          end else begin
            digit_d = hund_q;
            idx_d   = 2'd0;
          end
        end
      end
      S_EMIT: begin
        if (xfer) begin
          case (idx_q)
            2'd0: begin
              digit_d = tens_q;
              idx_d   = 2'd1;
            end
            2'd1: begin
              digit_d = rem_q[3:0];
              idx_d   = 2'd2;
            end
            2'd2: begin
              if (is_int && POINT_EN) begin
                digit_d = 4'hA;
                idx_d   = 2'd3;
              end else begin
                digit_valid_d = 1'b0;
                state_d       = S_NEXT;
              end
            end
            default: begin
              digit_valid_d = 1'b0;
              state_d       = S_NEXT;
            end
          endcase
        end
      end
      S_NEXT: begin
        if (rd_addr_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          rd_addr_d  = rd_addr_q - ADR_BITS'(1);
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rd_addr_q     <= '0;
      wait_cnt_q    <= '0;
      rem_q         <= '0;
      hund_q        <= '0;
      tens_q        <= '0;
      idx_q         <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      wait_cnt_q    <= wait_cnt_d;
      rem_q         <= rem_d;
      hund_q        <= hund_d;
      tens_q        <= tens_d;
      idx_q         <= idx_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_digit_reader.sv
// Directed bench for digit_reader: RAM model, digit scoreboard, stall, error and reset cases.
module tb_digit_reader;

  localparam int L        = 60;
  localparam int ADR_BITS = 6;
  localparam int N        = 10;
  localparam int RAMDELAY = 2;
`ifdef DIGIT_READER_POINT_EN
  localparam bit POINT_EN = 1'b1;
`else
  localparam bit POINT_EN = 1'b0;
`endif
  localparam int EXP_TOTAL = 3 * (L - 1) + 1 + (POINT_EN ? 1 : 0);

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ADR_BITS-1:0] rd_addr;
  logic [N-1:0]        rd_data;
  logic [3:0]          digit;
  logic                digit_valid;
  logic                digit_ready;
  logic                busy;
  logic                done;
  logic                err;

  logic [N-1:0] mem [0:L-1];
  logic [3:0]   exp_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  digit_reader #(.L(L), .ADR_BITS(ADR_BITS), .N(N), .RAMDELAY(RAMDELAY)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .digit      (digit),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // clock / RAM model: data for a new address is ready by the 2nd edge after it changes
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic build_expected();
    int w;
    exp_q.delete();
    exp_q.push_back(4'(int'(mem[L-1]) % 10));
    if (POINT_EN) exp_q.push_back(4'hA);
    for (int a = L - 2; a >= 0; a--) begin
      w = int'(mem[a]);
      if (w > 999) begin
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd9);
      end else begin
        exp_q.push_back(4'(w / 100));
        exp_q.push_back(4'((w / 10) % 10));
        exp_q.push_back(4'(w % 10));
      end
    end
  endtask

  // Starts a readout and consumes digits; stop_after>0 ends early, start is re-pulsed at busy_start_at.
  task automatic run_readout(input int ready_pct, input int stop_after, input int busy_start_at,
                             output int n_got, output logic [3:0] first_dig);
    int         target;
    int         cycles;
    logic       stalled;
    logic       r;
    logic [3:0] held;
    logic [3:0] e;
    build_expected();
    target    = (stop_after > 0) ? stop_after : exp_q.size();
    n_got     = 0;
    first_dig = 4'hF;
    stalled   = 1'b0;
    held      = 4'h0;
    cycles    = 0;
    @(negedge clk);
    start       = 1'b1;
    digit_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_addr", rd_addr, L - 1);
    check_eq("start_done", done, 0);
    check_eq("start_err", err, 0);
    while (cycles < 20000) begin
      if (stalled) begin
        check_eq("stall_valid", digit_valid, 1);
        check_eq("stall_hold", digit, held);
      end
      stalled = 1'b0;
      start   = (cycles == busy_start_at);
      if (n_got == target) break;
      r = ($urandom_range(99) < ready_pct);
      digit_ready = r;
      if (digit_valid && r) begin
        e = exp_q.pop_front();
        check_eq($sformatf("digit%0d", n_got), digit, e);
        if (n_got == 0) first_dig = digit;
        n_got++;
      end else if (digit_valid) begin
        stalled = 1'b1;
        held    = digit;
      end
      @(negedge clk);
      cycles++;
    end
    start       = 1'b0;
    digit_ready = 1'b0;
    check_eq("transfers", n_got, target);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 10 && !done; k++) @(negedge clk);
    check_eq("done", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_valid", digit_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr"}, rd_addr, 0);
    check_eq({tag, "_digit"}, digit, 0);
    check_eq({tag, "_valid"}, digit_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  initial begin
    int         n;
    logic [3:0] fd;
    rst         = 1'b0;
    start       = 1'b0;
    digit_ready = 1'b0;
    for (int a = 0; a < L; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // pi prefix, consumer always ready
    mem[59] = 10'd3;
    mem[58] = 10'd141;
    mem[57] = 10'd592;
    mem[56] = 10'd653;
    run_readout(100, 0, -1, n, fd);
    check_eq("pi_first", fd, 3);
    check_eq("pi_count", n, EXP_TOTAL);
    wait_done();
    check_eq("pi_err", err, 0);

    // leading zeros, 30% ready, start re-pulsed while busy
    mem[58] = 10'd7;
    mem[57] = 10'd40;
    run_readout(30, 0, 30, n, fd);
    check_eq("lz_count", n, EXP_TOTAL);
    wait_done();

    // out-of-range word
    mem[58] = 10'd1023;
    run_readout(100, 0, -1, n, fd);
    wait_done();
    check_eq("oor_err", err, 1);

    // reset in the middle of a readout (start inside also checks err cleared)
    mem[58] = 10'd141;
    mem[57] = 10'd592;
    run_readout(100, 50, -1, n, fd);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    run_readout(100, 0, -1, n, fd);
    check_eq("restart_first", fd, 3);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
